// File: rtl/sig_generator.sv
// Pulse-burst generator: N pulses of H active cycles, each followed by L idle cycles.
// Polarity set by EDGE; supports abort and an end-of-burst done strobe.
module sig_generator #(
    parameter int WIDTH = 1,
    parameter int EDGE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       num,
    input  logic [7:0]       high_len,
    input  logic [7:0]       low_len,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic [7:0]       remaining
);

    localparam logic [WIDTH-1:0] IDLE_LVL = (EDGE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ACT_LVL  = ~IDLE_LVL;

    typedef enum logic [1:0] {
        IDLE,
        ACT,
        GAP
    } state_t;

    state_t     state;
    logic [7:0] h_len;
    logic [7:0] l_len;
    logic [7:0] cnt;
    logic [7:0] h_eff;
    logic [7:0] l_eff;

    // Zero-length phases are stretched to one cycle.
    assign h_eff = (high_len == 8'd0) ? 8'd1 : high_len;
    assign l_eff = (low_len == 8'd0) ? 8'd1 : low_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sig       <= IDLE_LVL;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= 8'd0;
            h_len     <= 8'd0;
            l_len     <= 8'd0;
            cnt       <= 8'd0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                sig       <= IDLE_LVL;
                busy      <= 1'b0;
                remaining <= 8'd0;
                h_len     <= 8'd0;
                l_len     <= 8'd0;
                cnt       <= 8'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (num != 8'd0) begin
                                state     <= ACT;
                                sig       <= ACT_LVL;
                                busy      <= 1'b1;
                                remaining <= num;
                                h_len     <= h_eff;
                                l_len     <= l_eff;
                                cnt       <= 8'd1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ACT: begin
                        if (cnt == h_len) begin
                            state     <= GAP;
                            sig       <= IDLE_LVL;
                            remaining <= remaining - 8'd1;
                            cnt       <= 8'd1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    GAP: begin
                        if (cnt == l_len) begin
                            if (remaining != 8'd0) begin
                                state <= ACT;
                                sig   <= ACT_LVL;
                                cnt   <= 8'd1;
                            end else begin
                                // Trailing gap finished: burst complete.
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                h_len <= 8'd0;
                                l_len <= 8'd0;
                                cnt   <= 8'd0;
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sig   <= IDLE_LVL;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sig_generator.sv
// Bench for sig_generator: two instances (EDGE=0/W=1 and EDGE=1/W=4) share stimulus
// and are checked every cycle against a burst-timing model plus literal patterns.
module tb_sig_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num = 8'd0;
    logic [7:0] high_len = 8'd0;
    logic [7:0] low_len = 8'd0;

    logic [0:0] sig0;
    logic [3:0] sig1;
    logic       busy0, done0, busy1, done1;
    logic [7:0] rem0, rem1;

    always #5 clk = ~clk;

    sig_generator #(.WIDTH(1), .EDGE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num(num), .high_len(high_len), .low_len(low_len),
        .sig(sig0), .busy(busy0), .done(done0), .remaining(rem0)
    );

    sig_generator #(.WIDTH(4), .EDGE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num(num), .high_len(high_len), .low_len(low_len),
        .sig(sig1), .busy(busy1), .done(done1), .remaining(rem1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Burst model: outputs derived from the pulse-schedule formulas.
    int  ecnt = 0;
    int  t0 = 0;
    int  m_n = 0;
    int  m_h = 1;
    int  m_l = 1;
    bit  in_b = 1'b0;
    bit  zd = 1'b0;
    bit  e_act, e_busy, e_done;
    int  e_rem;
    int  j_m, p_m, tot_m, k_m, off_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_b <= 1'b0;
            zd   <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            zd   <= 1'b0;
            if (e_busy && abort) begin
                in_b <= 1'b0;
            end else if (!e_busy && start) begin
                if (num != 8'd0) begin
                    in_b <= 1'b1;
                    t0   <= ecnt;
                    m_n  <= int'(num);
                    m_h  <= (high_len == 8'd0) ? 1 : int'(high_len);
                    m_l  <= (low_len == 8'd0) ? 1 : int'(low_len);
                end else begin
                    in_b <= 1'b0;
                    zd   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        e_act  = 1'b0;
        e_busy = 1'b0;
        e_done = zd;
        e_rem  = 0;
        j_m    = ecnt - t0;
        p_m    = m_h + m_l;
        tot_m  = m_n * p_m;
        k_m    = 0;
        off_m  = 0;
        if (in_b) begin
            if (j_m >= 1 && j_m <= tot_m) begin
                k_m    = (j_m - 1) / p_m;
                off_m  = (j_m - 1) % p_m;
                e_act  = (off_m < m_h);
                e_busy = 1'b1;
                e_rem  = m_n - k_m - ((off_m >= m_h) ? 1 : 0);
            end else if (j_m == tot_m + 1) begin
                e_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_sig0", 64'(sig0), e_act ? 64'h1 : 64'h0);
            chk("m_sig1", 64'(sig1), e_act ? 64'h0 : 64'hF);
            chk("m_busy0", 64'(busy0), 64'(e_busy));
            chk("m_busy1", 64'(busy1), 64'(e_busy));
            chk("m_done0", 64'(done0), 64'(e_done));
            chk("m_done1", 64'(done1), 64'(e_done));
            chk("m_rem0", 64'(rem0), 64'(e_rem));
            chk("m_rem1", 64'(rem1), 64'(e_rem));
        end
    end

    // Downstream edge counters, one per polarity.
    logic [7:0] ec0 = 8'd0;
    logic [7:0] ec1 = 8'd0;
    logic       p0 = 1'b0;
    logic       p1 = 1'b1;

    always @(posedge clk) begin
        p0 <= sig0[0];
        p1 <= sig1[0];
        if (sig0[0] && !p0) ec0 <= ec0 + 8'd1;
        if (!sig1[0] && p1) ec1 <= ec1 + 8'd1;
    end

    task automatic go(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l);
        start    = 1'b1;
        num      = n;
        high_len = h;
        low_len  = l;
    endtask

    task automatic wait_done(input int lim, input string nm, output int act_cnt);
        int i;
        i = 0;
        act_cnt = 0;
        while (!done0 && i < lim) begin
            @(negedge clk);
            start = 1'b0;
            if (sig0[0]) act_cnt++;
            i++;
        end
        chk(nm, 64'(done0), 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [9:0]  sv, dv, bv;
    logic [39:0] rv;
    logic [19:0] s1v;
    logic [4:0]  d1v;
    logic [3:0]  cd, cb, cs0;
    logic [15:0] cs1;
    logic [9:0]  x_sig, x_done, x_busy;
    logic [39:0] x_rem;
    logic [19:0] x_s1;
    logic [7:0]  b0, b1;
    int          ac;

    initial begin
        #1 rst_n = 1'b0;
        #3;
        chk("rst_sig0", 64'(sig0), 64'h0);
        chk("rst_sig1", 64'(sig1), 64'hF);
        chk("rst_busy", 64'(busy0), 64'h0);
        chk("rst_done", 64'(done0), 64'h0);
        chk("rst_rem", 64'(rem1), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // N=3 H=2 L=1, with an ignored start mid-burst.
        go(8'd3, 8'd2, 8'd1);
        sv = '0; dv = '0; bv = '0; rv = '0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            sv = {sv[8:0], sig0[0]};
            dv = {dv[8:0], done0};
            bv = {bv[8:0], busy0};
            rv = {rv[35:0], rem0[3:0]};
            start = 1'b0;
            if (j == 4) go(8'd7, 8'd9, 8'd5);
        end
        x_sig  = 10'b1101101100;
        x_done = 10'b0000000001;
        x_busy = 10'b1111111110;
        x_rem  = 40'h3322211100;
        chk("a_sig", 64'(sv), 64'(x_sig));
        chk("a_done", 64'(dv), 64'(x_done));
        chk("a_busy", 64'(bv), 64'(x_busy));
        chk("a_rem", 64'(rv), 64'(x_rem));
        repeat (2) @(negedge clk);

        // N=2 H=0 L=0 on the inverted 4-bit instance.
        go(8'd2, 8'd0, 8'd0);
        s1v = '0; d1v = '0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            start = 1'b0;
            s1v = {s1v[15:0], sig1};
            d1v = {d1v[3:0], done1};
        end
        x_s1 = 20'h0F0FF;
        chk("b_sig1", 64'(s1v), 64'(x_s1));
        chk("b_done1", 64'(d1v), 64'h01);
        repeat (2) @(negedge clk);

        // num=0: done only, no pulse; abort in IDLE ignored.
        go(8'd0, 8'd4, 8'd4);
        cd = '0; cb = '0; cs0 = '0; cs1 = '0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (j == 2);
            cd  = {cd[2:0], done0};
            cb  = {cb[2:0], busy0};
            cs0 = {cs0[2:0], sig0[0]};
            cs1 = {cs1[11:0], sig1};
        end
        abort = 1'b0;
        chk("c_done", 64'(cd), 64'h8);
        chk("c_busy", 64'(cb), 64'h0);
        chk("c_sig0", 64'(cs0), 64'h0);
        chk("c_sig1", 64'(cs1), 64'hFFFF);
        @(negedge clk);

        // Abort mid-pulse (with start), then restart with start+abort in IDLE.
        go(8'd5, 8'd3, 8'd3);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (j == 8) begin
                chk("d_sig_pre", 64'(sig0), 64'h1);
                abort = 1'b1;
                start = 1'b1;
            end
            if (j == 9) begin
                chk("d_sig", 64'(sig0), 64'h0);
                chk("d_busy", 64'(busy0), 64'h0);
                chk("d_rem", 64'(rem0), 64'h0);
                chk("d_done", 64'(done0), 64'h0);
            end
            if (j == 10) begin
                go(8'd1, 8'd1, 8'd1);
                abort = 1'b1;
            end
            if (j == 11) begin
                chk("d_restart_busy", 64'(busy0), 64'h1);
                chk("d_restart_sig", 64'(sig1), 64'h0);
            end
        end
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges during ACT.
        go(8'd3, 8'd4, 8'd2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("e_sig_act", 64'(sig0), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("e_sig0", 64'(sig0), 64'h0);
        chk("e_sig1", 64'(sig1), 64'hF);
        chk("e_busy", 64'(busy0), 64'h0);
        chk("e_rem", 64'(rem0), 64'h0);
        chk("e_done", 64'(done0), 64'h0);
        #1 rst_n = 1'b1;
        go(8'd1, 8'd0, 8'd0);
        @(negedge clk);
        start = 1'b0;
        chk("e_first_edge", 64'(busy0), 64'h1);
        repeat (3) @(negedge clk);

        // Counter limits: H=255, then N=255.
        go(8'd1, 8'd255, 8'd0);
        wait_done(300, "f_h255_timeout", ac);
        chk("f_h255_len", 64'(ac), 64'd255);
        @(negedge clk);
        b0 = ec0;
        go(8'd255, 8'd0, 8'd0);
        wait_done(600, "f_n255_timeout", ac);
        chk("f_n255_cnt", 64'(8'(ec0 - b0)), 64'd255);
        @(negedge clk);

        // Loopback: 200 pulses, then back-to-back burst started at done.
        b0 = ec0;
        b1 = ec1;
        go(8'd200, 8'd1, 8'd1);
        wait_done(450, "g_timeout1", ac);
        chk("g_cnt0", 64'(8'(ec0 - b0)), 64'd200);
        chk("g_cnt1", 64'(8'(ec1 - b1)), 64'd200);
        go(8'd3, 8'd1, 8'd1);
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("g_b2b_busy", 64'(busy0), 64'h1);
        wait_done(20, "g_timeout2", ac);
        chk("g_cnt0_2", 64'(8'(ec0 - b0)), 64'd203);
        chk("g_cnt1_2", 64'(8'(ec1 - b1)), 64'd203);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
